// File: rtl/sram_port_arbiter_if.sv
// Port bundle between the SRAM port arbiter and its surroundings: the two requesters
// and the 8-macro SRAM array (2 banks x 4 byte lanes).
interface sram_port_arbiter_if;
  logic        req0, lock0, wr0;
  logic [13:0] addr0;
  logic [3:0]  be0;
  logic [31:0] wdata0;
  logic        gnt0, rvalid0;
  logic        req1, lock1, wr1;
  logic [13:0] addr1;
  logic [3:0]  be1;
  logic [31:0] wdata1;
  logic        gnt1, rvalid1;
  logic [31:0] rdata;
  logic        sram_w_en;
  logic [12:0] sram_addr_out;
  logic [31:0] sram_wdata;
  logic [3:0]  bank0_csn, bank1_csn;
  logic [63:0] sram_q;

  modport slave (
    input  req0, lock0, wr0, addr0, be0, wdata0,
    input  req1, lock1, wr1, addr1, be1, wdata1, sram_q,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output sram_w_en, sram_addr_out, sram_wdata, bank0_csn, bank1_csn
  );

  modport master (
    output req0, lock0, wr0, addr0, be0, wdata0,
    output req1, lock1, wr1, addr1, be1, wdata1, sram_q,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  sram_w_en, sram_addr_out, sram_wdata, bank0_csn, bank1_csn
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the shared SRAM control port: round robin when idle,
// lockable ownership bounded by MAX_HOLD, registered command, fixed 2-cycle read return.
module sram_port_arbiter #(
  parameter int MAX_HOLD   = 16,
  parameter bit RESET_PRIO = 1'b0
) (
  input logic                hclk,
  input logic                hresetn,
  sram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t           r_state, w_state_nxt;
  logic             r_last;
  logic [7:0]       r_hold, w_hold_nxt;
  logic [1:0]       w_req, w_lock, w_wr, w_gnt;
  logic [1:0][13:0] w_addr_v;
  logic [1:0][3:0]  w_be_v;
  logic [1:0][31:0] w_wdata_v;
  logic             w_own, w_locked, w_any, w_win;
  logic             w_sel_wr;
  logic [13:0]      w_sel_addr;
  logic [3:0]       w_sel_be;
  logic [31:0]      w_sel_wdata;

  logic [1:0][3:0]  r_csn;
  logic             r_w_en;
  logic [12:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_rd_vld, r_rd_id, r_rd_bank;
  logic [1:0]       r_rvalid;
  logic [31:0]      r_rdata;

  assign w_req     = {bus.req1, bus.req0};
  assign w_lock    = {bus.lock1, bus.lock0};
  assign w_wr      = {bus.wr1, bus.wr0};
  assign w_addr_v  = {bus.addr1, bus.addr0};
  assign w_be_v    = {bus.be1, bus.be0};
  assign w_wdata_v = {bus.wdata1, bus.wdata0};

  always_comb begin
    w_own       = (r_state == OWN1);
    w_locked    = (r_state != IDLE);
    w_any       = 1'b0;
    w_win       = 1'b0;
    w_state_nxt = IDLE;
    w_hold_nxt  = 8'd0;
    // An owner that dropped its request falls through to normal arbitration.
    if (w_locked && w_req[w_own]) begin
      w_any = 1'b1;
      w_win = (r_hold >= HOLD_LIM && w_req[~w_own]) ? ~w_own : w_own;
    end else if (|w_req) begin
      w_any = 1'b1;
      w_win = (&w_req) ? ~r_last : w_req[1];
    end
    if (w_any && w_lock[w_win]) begin
      w_state_nxt = w_win ? OWN1 : OWN0;
      if (w_locked && (w_win == w_own))
        w_hold_nxt = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
      else
        w_hold_nxt = 8'd1;
    end
    w_gnt[0] = w_any && !w_win && hresetn;
    w_gnt[1] = w_any &&  w_win && hresetn;
  end

  assign w_sel_wr    = w_wr[w_win];
  assign w_sel_addr  = w_addr_v[w_win];
  assign w_sel_be    = w_be_v[w_win];
  assign w_sel_wdata = w_wdata_v[w_win];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= IDLE;
      r_last  <= ~RESET_PRIO;
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      if (w_any) r_last <= w_win;
    end
  end

  // Command register: idle values every cycle unless an access was accepted.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_csn     <= '1;
      r_w_en    <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_id   <= 1'b0;
      r_rd_bank <= 1'b0;
      r_rvalid  <= '0;
      r_rdata   <= '0;
    end else begin
      r_csn     <= '1;
      r_w_en    <= 1'b1;
      r_rd_vld  <= w_any && !w_sel_wr;
      r_rd_id   <= w_win;
      r_rd_bank <= w_sel_addr[13];
      if (w_any) begin
        r_addr                  <= w_sel_addr[12:0];
        r_w_en                  <= ~w_sel_wr;
        r_csn[w_sel_addr[13]]   <= w_sel_wr ? ~w_sel_be : 4'h0;
        if (w_sel_wr) r_wdata   <= w_sel_wdata;
      end
      // SRAM answered on the falling edge of the command cycle; capture it now.
      r_rvalid <= '0;
      if (r_rd_vld) begin
        r_rvalid[r_rd_id] <= 1'b1;
        r_rdata           <= r_rd_bank ? bus.sram_q[63:32] : bus.sram_q[31:0];
      end
    end
  end

  assign bus.gnt0          = w_gnt[0];
  assign bus.gnt1          = w_gnt[1];
  assign bus.rvalid0       = r_rvalid[0];
  assign bus.rvalid1       = r_rvalid[1];
  assign bus.rdata         = r_rdata;
  assign bus.sram_w_en     = r_w_en;
  assign bus.sram_addr_out = r_addr;
  assign bus.sram_wdata    = r_wdata;
  assign bus.bank0_csn     = r_csn[0];
  assign bus.bank1_csn     = r_csn[1];
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM array model, per-cycle reference check against a
// transaction-level arbiter/memory model, and directed scenarios with literal results.
module tb_sram_port_arbiter;
  localparam int MAXH = 4;
  localparam bit PRIO = 1'b0;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  sram_port_arbiter_if bus();

  sram_port_arbiter #(.MAX_HOLD(MAXH), .RESET_PRIO(PRIO)) dut (
    .hclk(hclk), .hresetn(hresetn), .bus(bus)
  );

  always #5 hclk = ~hclk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] initword(input logic [13:0] a);
    return {2'b10, a, 2'b01, a};
  endfunction

  // ---------------- SRAM array: 2 banks x 4 lanes of 8Kx8, clocked on ~hclk
  logic [7:0]  smem [0:1][0:3][0:8191];
  logic [63:0] s_q = '0;
  logic [7:0]  s_csn;
  assign s_csn = {bus.bank1_csn, bus.bank0_csn};
  assign bus.sram_q = s_q;

  always @(negedge hclk) begin
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 4; l++)
        if (!s_csn[4*b+l]) begin
          if (!bus.sram_w_en) smem[b][l][bus.sram_addr_out] = bus.sram_wdata[8*l +: 8];
          else                s_q[32*b+8*l +: 8] <= smem[b][l][bus.sram_addr_out];
        end
  end

  // ---------------- reference model: words, grants, pending reads
  typedef struct packed {
    logic        v;
    logic        id;
    logic        wr;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } acc_t;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] d;
  } rv_t;

  logic [31:0] ref_mem [0:16383];
  int   m_own, m_run, m_last, m_w;
  bit   m_rq [2];
  acc_t g1, g2, cur;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_csn [2];
  logic        e_wen, e_rv0, e_rv1;
  int   cycnt = 0;
  int   gq[$];
  rv_t  rq[$];

  initial begin
    for (int a = 0; a < 16384; a++) begin
      ref_mem[a] = initword(14'(a));
      for (int l = 0; l < 4; l++) smem[a >> 13][l][a & 8191] = ref_mem[a][8*l +: 8];
    end
  end

  always begin
    @(posedge hclk);
    #7;
    gq.push_back(bus.gnt0 ? 0 : (bus.gnt1 ? 1 : 2));
    if (bus.rvalid0) rq.push_back('{cycnt, 0, bus.rdata});
    if (bus.rvalid1) rq.push_back('{cycnt, 1, bus.rdata});
    if (!hresetn) begin
      chk("rst_gnt0", 32'(bus.gnt0), 0);
      chk("rst_gnt1", 32'(bus.gnt1), 0);
      chk("rst_rv", 32'({bus.rvalid1, bus.rvalid0}), 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_csn", 32'({bus.bank1_csn, bus.bank0_csn}), 32'hFF);
      chk("rst_wen", 32'(bus.sram_w_en), 1);
      chk("rst_addr", 32'(bus.sram_addr_out), 0);
      chk("rst_wdata", bus.sram_wdata, 0);
      m_own = -1; m_run = 0; m_last = PRIO ? 0 : 1;
      g1 = '0; g2 = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else begin
      m_rq[0] = bus.req0; m_rq[1] = bus.req1;
      m_w = -1;
      if (m_own >= 0 && m_rq[m_own]) begin
        m_w = (m_run >= MAXH && m_rq[1-m_own]) ? 1 - m_own : m_own;
      end else if (m_rq[0] && m_rq[1]) m_w = 1 - m_last;
      else if (m_rq[0]) m_w = 0;
      else if (m_rq[1]) m_w = 1;

      e_csn[0] = 4'hF; e_csn[1] = 4'hF; e_wen = 1'b1;
      if (g1.v) begin
        e_addr = 32'(g1.addr[12:0]);
        e_wen  = ~g1.wr;
        e_csn[g1.addr[13]] = g1.wr ? ~g1.be : 4'h0;
        if (g1.wr) e_wdata = g1.wdata;
      end
      e_rv0 = g2.v && !g2.wr && !g2.id;
      e_rv1 = g2.v && !g2.wr &&  g2.id;
      if (e_rv0 || e_rv1) e_rdata = g2.rd;

      chk("gnt0", 32'(bus.gnt0), 32'(m_w == 0));
      chk("gnt1", 32'(bus.gnt1), 32'(m_w == 1));
      chk("rvalid0", 32'(bus.rvalid0), 32'(e_rv0));
      chk("rvalid1", 32'(bus.rvalid1), 32'(e_rv1));
      chk("rdata", bus.rdata, e_rdata);
      chk("bank0_csn", 32'(bus.bank0_csn), 32'(e_csn[0]));
      chk("bank1_csn", 32'(bus.bank1_csn), 32'(e_csn[1]));
      chk("sram_w_en", 32'(bus.sram_w_en), 32'(e_wen));
      chk("sram_addr", 32'(bus.sram_addr_out), e_addr);
      chk("sram_wdata", bus.sram_wdata, e_wdata);

      cur = '0;
      if (m_w >= 0) begin
        cur.v     = 1'b1;
        cur.id    = (m_w == 1);
        cur.wr    = m_w ? bus.wr1 : bus.wr0;
        cur.addr  = m_w ? bus.addr1 : bus.addr0;
        cur.be    = m_w ? bus.be1 : bus.be0;
        cur.wdata = m_w ? bus.wdata1 : bus.wdata0;
        if (!cur.wr) cur.rd = ref_mem[cur.addr];
        else
          for (int l = 0; l < 4; l++)
            if (cur.be[l]) ref_mem[cur.addr][8*l +: 8] = cur.wdata[8*l +: 8];
        m_last = m_w;
        if ((m_w ? bus.lock1 : bus.lock0)) begin
          if (m_w == m_own) m_run = (m_run < 255) ? m_run + 1 : 255;
          else begin m_own = m_w; m_run = 1; end
        end else begin
          m_own = -1; m_run = 0;
        end
      end else begin
        m_own = -1; m_run = 0;
      end
      g2 = g1; g1 = cur;
    end
    cycnt++;
  end

  // ---------------- directed stimulus
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  int base;
  int hold_exp [6];
  int alt_exp  [6];

  initial begin
    bus.req0 = 0; bus.lock0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.be0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.lock1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.be1 = '0; bus.wdata1 = '0;
    hold_exp = '{0, 0, 0, 0, 1, 0};
    alt_exp  = '{0, 1, 0, 1, 0, 1};
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    step();

    // single read of bank 0, word 5
    rq.delete(); base = cycnt;
    bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 14'h0005;
    step(); bus.req0 = 0; #6;
    chk("t1_csn0", 32'(bus.bank0_csn), 32'h0);
    chk("t1_csn1", 32'(bus.bank1_csn), 32'hF);
    chk("t1_wen", 32'(bus.sram_w_en), 1);
    chk("t1_addr", 32'(bus.sram_addr_out), 5);
    repeat (3) step();
    chk("t1_nrv", rq.size(), 1);
    if (rq.size() > 0) begin
      chk("t1_lat", rq[0].cyc - base, 2);
      chk("t1_id", rq[0].id, 0);
      chk("t1_data", rq[0].d, 32'h8005_4005);
    end

    // partial write to bank 1, immediately read back
    rq.delete(); base = cycnt;
    bus.req0 = 1; bus.wr0 = 1; bus.addr0 = 14'h2010; bus.be0 = 4'b0101; bus.wdata0 = 32'hA5A5_5A5A;
    step(); bus.wr0 = 0; #6;
    chk("t2_csn1", 32'(bus.bank1_csn), 32'hA);
    chk("t2_csn0", 32'(bus.bank0_csn), 32'hF);
    chk("t2_wen", 32'(bus.sram_w_en), 0);
    chk("t2_wdata", bus.sram_wdata, 32'hA5A5_5A5A);
    step(); bus.req0 = 0;
    repeat (3) step();
    chk("t2_nrv", rq.size(), 1);
    if (rq.size() > 0) begin
      chk("t2_lat", rq[0].cyc - base, 3);
      chk("t2_data", rq[0].d, 32'hA0A5_605A);
    end

    // locked requester 0 against a pending requester 1, hold limit 4
    gq.delete(); base = cycnt;
    bus.req0 = 1; bus.lock0 = 1; bus.wr0 = 0; bus.addr0 = 14'h0003;
    bus.wr1 = 0; bus.addr1 = 14'h2003;
    step(); bus.req1 = 1;
    repeat (5) step();
    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0;
    repeat (3) step();
    chk("t3_ngq", 32'(gq.size() >= 6), 1);
    if (gq.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("t3_gnt%0d", i), gq[i], hold_exp[i]);

    // reset in the cycle after a requester 1 read is granted
    rq.delete();
    bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 14'h2040;
    step(); hresetn = 1'b0; bus.addr1 = 14'h2041; #6;
    chk("t4_csn", 32'({bus.bank1_csn, bus.bank0_csn}), 32'hFF);
    chk("t4_wen", 32'(bus.sram_w_en), 1);
    step(); step();
    chk("t4_norv", rq.size(), 0);
    hresetn = 1'b1;

    // first conflict after release, then plain round robin
    gq.delete(); rq.delete(); base = cycnt;
    bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 14'h0100;
    bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 14'h2200;
    repeat (6) step();
    bus.req0 = 0; bus.req1 = 0;
    repeat (3) step();
    chk("t5_ngq", 32'(gq.size() >= 6), 1);
    if (gq.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("t5_gnt%0d", i), gq[i], alt_exp[i]);
    chk("t5_nrv", rq.size(), 6);
    if (rq.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t5_id%0d", i), rq[i].id, alt_exp[i]);
        chk($sformatf("t5_lat%0d", i), rq[i].cyc - base, i + 2);
        chk($sformatf("t5_d%0d", i), rq[i].d, alt_exp[i] ? 32'hA200_6200 : 32'h8100_4100);
      end

    // requester 1: write, read back, empty-byte-enable write, read back
    rq.delete(); base = cycnt;
    bus.req1 = 1; bus.wr1 = 1; bus.addr1 = 14'h0333; bus.be1 = 4'hF; bus.wdata1 = 32'h1234_5678;
    step(); bus.wr1 = 0;
    step(); bus.wr1 = 1; bus.be1 = 4'h0; bus.wdata1 = 32'hFFFF_FFFF;
    step(); bus.wr1 = 0; #6;
    chk("t6_be0_csn", 32'({bus.bank1_csn, bus.bank0_csn}), 32'hFF);
    chk("t6_be0_wen", 32'(bus.sram_w_en), 0);
    step(); bus.req1 = 0;
    repeat (3) step();
    chk("t6_nrv", rq.size(), 2);
    if (rq.size() == 2) begin
      chk("t6_lat0", rq[0].cyc - base, 3);
      chk("t6_id0", rq[0].id, 1);
      chk("t6_d0", rq[0].d, 32'h1234_5678);
      chk("t6_lat1", rq[1].cyc - base, 5);
      chk("t6_d1", rq[1].d, 32'h1234_5678);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
